multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multicycle successor to the single-cycle opcode decoder. A Moore FSM sequences each
//  instruction over 3-5 cycles and drives the shared-ALU / unified-memory datapath.
//  It waits on a memory ready handshake and flags illegal opcodes.
//  It counts retired instructions.
//  Sits between the instruction register opcode field and the datapath mux/enable controls.
// PARAMETERS
//  OPCODE_W  3   opcode width; values >7 are illegal
//  CNT_W     16  width of retired-instruction counter
// PORTS
//  Clock       in   1        rising-edge clock
//  Reset       in   1        asynchronous, active-high reset
//  Opcode      in   OPCODE_W opcode from IR: 0 R-type, 1 andi, 2 ori, 3 addi, 4 slti, 5 lw, 6 sw, 7 bne
//  MemReady    in   1        memory completes current read/write this cycle
//  PCWrite     out  1        unconditional PC load
//  PCWriteCond out  1        PC load if ALU Zero==0 (bne)
//  IorD        out  1        memory address: 0=PC, 1=ALUOut
//  MemRead     out  1        memory read request
//  MemWrite    out  1        memory write request
//  IRWrite     out  1        load instruction register
//  MemToReg    out  1        writeback source: 0=ALUOut, 1=MDR
//  RegDst      out  1        dest reg: 1=rd, 0=rt
//  RegWrite    out  1        register file write enable
//  ALUSrcA     out  1        0=PC, 1=rs
//  ALUSrcB     out  2        00=rt, 01=const 1, 10=imm, 11=imm branch offset
//  ALUOp       out  2        00 add, 01 sub/compare, 10 funct-decoded, 11 imm-op-decoded
//  PCSource    out  1        0=ALU result, 1=ALUOut (branch target)
//  InstrDone   out  1        1-cycle pulse in final cycle of each retired instruction
//  Illegal     out  1        1-cycle pulse when DECODE sees an illegal opcode
//  Retired     out  CNT_W    retired-instruction count
//  State       out  4        current state encoding (debug)
// BEHAVIOUR
//  - Reset (async) forces State=IDLE and Retired=0. All outputs are 0 while Reset is high.
//    This holds mid-instruction; no partial writes complete.
//  - Outputs are decoded from State only. Exception: IRWrite/PCWrite in FETCH are gated by MemReady.
//    Unlisted outputs are 0 in each state.
//  - Opcode is latched internally in DECODE. MEMADDR uses the latched copy; Opcode is ignored elsewhere.
//  States (encoding) / outputs -> next:
//   IDLE(0):    none -> FETCH
//   FETCH(1):   MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, IRWrite=PCWrite=MemReady;
//               stay while !MemReady, else -> DECODE
//   DECODE(2):  ALUSrcA=0, ALUSrcB=11, ALUOp=00
//               -> op0: EXEC_R; op1-4: EXEC_I; op5/6: MEMADDR; op7: BRANCH
//               -> illegal: FETCH, Illegal=1; no InstrDone
//   EXEC_R(3):  ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_R
//   WB_R(4):    RegDst=1, RegWrite, MemToReg=0, InstrDone -> FETCH
//   EXEC_I(5):  ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> WB_I
//   WB_I(6):    RegDst=0, RegWrite, MemToReg=0, InstrDone -> FETCH
//   MEMADDR(7): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> lw: MEMRD, sw: MEMWR
//   MEMRD(8):   MemRead, IorD=1; stay while !MemReady -> MEMWB
//   MEMWB(9):   RegDst=0, MemToReg=1, RegWrite, InstrDone -> FETCH
//   MEMWR(10):  MemWrite, IorD=1; InstrDone=MemReady; stay while !MemReady -> FETCH
//   BRANCH(11): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=1, InstrDone -> FETCH
//   codes 12-15: unreachable; -> IDLE if entered
//  - Latency with MemReady tied 1: R/I-type 4, lw 5, sw 4, bne 3 cycles FETCH-to-FETCH.
//    Each wait cycle adds 1.
//  - Retired increments by 1 on every cycle with InstrDone=1. It wraps 2^CNT_W-1 -> 0 silently.
//  - MemReady is don't-care outside FETCH/MEMRD/MEMWR.
// TESTING
//  - Reset, MemReady=1, Opcode=0: State 0,1,2,3,4,1. RegDst=RegWrite=1 in state 4. Retired=1.
//  - Opcode=5, MemReady low 2 cycles in MEMRD: State 1,2,7,8,8,8,9. MemToReg=1 in 9. Cycles=7.
//  - Opcode=6 then 7: MemWrite only in 10. PCWriteCond=PCSource=1 in 11. Retired=2.
//  - OPCODE_W=4, Opcode=9: Illegal pulses in DECODE, then State=1. Retired unchanged.
//  - Preload Retired=0xFFFF via 65535 addi, then one more: Retired=0 (wrap).
//  - Assert Reset in MEMWR: MemWrite drops same cycle. State=0; next instruction fetches cleanly.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// ============================================================================
// multicycle_control_unit_if
// Opcode/handshake inputs and datapath control outputs of the multicycle FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                pc_source;
  logic                instr_done;
  logic                illegal;
  logic [CNT_W-1:0]    retired;
  logic [3:0]          state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal, retired, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal, retired, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit
// Moore FSM sequencing a shared-ALU / unified-memory multicycle datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_unit_if.master   bus
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC_R  = 4'd3;
  localparam logic [3:0] S_WB_R    = 4'd4;
  localparam logic [3:0] S_EXEC_I  = 4'd5;
  localparam logic [3:0] S_WB_I    = 4'd6;
  localparam logic [3:0] S_MEMADDR = 4'd7;
  localparam logic [3:0] S_MEMRD   = 4'd8;
  localparam logic [3:0] S_MEMWB   = 4'd9;
  localparam logic [3:0] S_MEMWR   = 4'd10;
  localparam logic [3:0] S_BRANCH  = 4'd11;

  logic [3:0]       state;
  logic [3:0]       next_state;
  logic             is_store;
  logic [CNT_W-1:0] retired_cnt;
  logic [31:0]      op_ext;
  logic             op_illegal;

  assign op_ext     = 32'(bus.opcode);
  assign op_illegal = (op_ext > 32'd7);

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:    next_state = S_FETCH;
      S_FETCH:   next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_illegal) begin
          next_state = S_FETCH;
        end else begin
          case (op_ext[2:0])
            3'd0:                      next_state = S_EXEC_R;
            3'd1, 3'd2, 3'd3, 3'd4:    next_state = S_EXEC_I;
            3'd5, 3'd6:                next_state = S_MEMADDR;
            default:                   next_state = S_BRANCH;
          endcase
        end
      end
      S_EXEC_R:  next_state = S_WB_R;
      S_WB_R:    next_state = S_FETCH;
      S_EXEC_I:  next_state = S_WB_I;
      S_WB_I:    next_state = S_FETCH;
      S_MEMADDR: next_state = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_BRANCH:  next_state = S_FETCH;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Only lw vs sw matters after DECODE, so that is all that is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store <= 1'b0;
    end else if (state == S_DECODE) begin
      is_store <= (op_ext[2:0] == 3'd6);
    end
  end

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, pc_source;
  logic       instr_done, illegal;
  logic [1:0] alu_src_b, alu_op;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = op_illegal;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_WB_R: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = bus.mem_ready;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        instr_done    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (instr_done) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.iord          = iord;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.instr_done    = instr_done;
  assign bus.illegal       = illegal;
  assign bus.retired       = retired_cnt;
  assign bus.state         = state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// tb_multicycle_control_unit
// Randomized instruction stream checked against a per-instruction state-trace model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  localparam int OPCODE_W = 4;
  localparam int CNT_W    = 8;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int model_retired = 0;

  typedef struct {
    int st;
    bit rdy;
  } step_t;

  step_t plan[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Control word order: pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb[2], aluop[2], pcsrc
  function automatic logic [14:0] pack_ctrl(bit pcw, bit pcwc, bit iord, bit mrd, bit mwr, bit irw,
                                            bit m2r, bit rdst, bit rw, bit srca, bit [1:0] srcb,
                                            bit [1:0] aluop, bit pcsrc);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc};
  endfunction

  function automatic logic [14:0] exp_ctrl(int st, bit rdy);
    case (st)
      1:  return pack_ctrl(rdy, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b01, 2'b00, 0);
      2:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0);
      3:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0);
      4:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
      5:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 0);
      6:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
      7:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0);
      8:  return pack_ctrl(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      9:  return pack_ctrl(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0);
      10: return pack_ctrl(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      11: return pack_ctrl(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [14:0] obs_ctrl();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_source};
  endfunction

  function automatic step_t mk(int st, bit rdy);
    step_t s;
    s.st  = st;
    s.rdy = rdy;
    return s;
  endfunction

  // Expected state trace of one instruction, waits expressed as extra cycles.
  task automatic build_plan(input int op, input int fwait, input int mwait);
    plan.delete();
    repeat (fwait) plan.push_back(mk(1, 1'b0));
    plan.push_back(mk(1, 1'b1));
    plan.push_back(mk(2, 1'($urandom)));
    case (op)
      0: begin
        plan.push_back(mk(3, 1'($urandom)));
        plan.push_back(mk(4, 1'($urandom)));
      end
      1, 2, 3, 4: begin
        plan.push_back(mk(5, 1'($urandom)));
        plan.push_back(mk(6, 1'($urandom)));
      end
      5: begin
        plan.push_back(mk(7, 1'($urandom)));
        repeat (mwait) plan.push_back(mk(8, 1'b0));
        plan.push_back(mk(8, 1'b1));
        plan.push_back(mk(9, 1'($urandom)));
      end
      6: begin
        plan.push_back(mk(7, 1'($urandom)));
        repeat (mwait) plan.push_back(mk(10, 1'b0));
        plan.push_back(mk(10, 1'b1));
      end
      7: plan.push_back(mk(11, 1'($urandom)));
      default: ;
    endcase
  endtask

  // Runs one instruction; stop_st >= 0 aborts right after the first cycle in that state.
  task automatic run_instr(input int op, input int fwait, input int mwait, input int stop_st);
    bit legal;
    bit last;
    legal = (op <= 7);
    build_plan(op, fwait, mwait);
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk);
      #1;
      bus.mem_ready = plan[i].rdy;
      bus.opcode    = (plan[i].st == 2) ? OPCODE_W'(op) : OPCODE_W'($urandom);
      #1;
      last = (i == plan.size() - 1);
      check_value("state", 32'(bus.state), 32'(plan[i].st));
      check_value("ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(plan[i].st, plan[i].rdy)));
      check_value("instr_done", 32'(bus.instr_done), 32'(last && legal));
      check_value("illegal", 32'(bus.illegal), 32'(plan[i].st == 2 && !legal));
      check_value("retired", 32'(bus.retired), 32'(model_retired % CNT_MOD));
      if (plan[i].st == stop_st) return;
      if (last && legal) model_retired++;
    end
  endtask

  task automatic check_idle(input string tag);
    check_value({tag, "_state"}, 32'(bus.state), 32'd0);
    check_value({tag, "_ctrl"}, 32'(obs_ctrl()), 32'd0);
    check_value({tag, "_done"}, 32'({bus.instr_done, bus.illegal}), 32'd0);
    check_value({tag, "_retired"}, 32'(bus.retired), 32'(model_retired % CNT_MOD));
  endtask

  initial begin
    int op;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    #12;
    check_idle("reset");
    rst = 1'b0;
    #1;
    check_idle("idle");

    run_instr(0, 0, 0, -1);
    run_instr(5, 0, 2, -1);
    run_instr(6, 0, 0, -1);
    run_instr(7, 0, 0, -1);
    run_instr(9, 0, 0, -1);
    run_instr(3, 1, 0, -1);

    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    end

    // Asynchronous reset while a store waits on memory.
    run_instr(6, 0, 3, 10);
    rst = 1'b1;
    #1;
    model_retired = 0;
    check_value("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check_idle("rst_memwr");
    #1;
    rst = 1'b0;
    check_idle("post_rst");
    run_instr(5, 0, 1, -1);
    run_instr(0, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
